// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC and instruction memory, issues reads under a credit
// limit, carries the read data through a MEM_LAT-deep pipeline and buffers it
// in a small prefetch FIFO that decode drains with a valid/ready handshake.
module fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_WORDS = 32,
  parameter int              DEPTH      = 4,
  parameter int              MEM_LAT    = 1,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] NOP        = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  input  logic                          inst_ready,
  output logic                          inst_valid,
  output logic [XLEN-1:0]               inst,
  output logic [XLEN-1:0]               inst_pc,
  output logic [$clog2(DEPTH):0]        fifo_count,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
  input  logic [XLEN-1:0]               prog_data
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Power-up content of the instruction store; reset leaves it untouched so a
  // loaded program survives a reset.
  logic [XLEN-1:0] mem [IMEM_WORDS] = '{default: NOP};

  logic [XLEN-1:0] pc;
  logic [AW-1:0]   rd_idx;
  logic [XLEN-1:0] rd_word;
  logic            issue;
  logic [2:0]      inflight;
  logic [CW+1:0]   credit_used;

  logic            push_valid;
  logic [XLEN-1:0] push_inst;
  logic [XLEN-1:0] push_pc;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] buf_inst [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign rd_idx  = pc[AW+1:2];
  assign rd_word = mem[rd_idx];

  // Credit check counts queued plus in-flight entries; a same-cycle pop is not
  // credited, which keeps the FIFO from ever being pushed while full.
  always_comb begin
    credit_used = (CW+2)'(count) + (CW+2)'(inflight);
    issue       = !redirect_valid && (credit_used < (CW+2)'(DEPTH));
  end

  // Program counter: reset, then redirect, then sequential advance on issue.
  always_ff @(posedge clk) begin
    if (!rst)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= redirect_target & ~XLEN'(3);
    else if (issue)
      pc <= pc + XLEN'(4);
  end

  // Loader write port; a read of the same word this cycle still sees old data.
  always_ff @(posedge clk) begin
    if (rst && prog_we)
      mem[prog_addr] <= prog_data;
  end

  generate
    if (MEM_LAT == 1) begin : g_direct
      assign push_valid = issue;
      assign push_inst  = rd_word;
      assign push_pc    = pc;
      assign inflight   = 3'd0;
    end else begin : g_line
      logic [MEM_LAT-2:0] dv;
      logic [XLEN-1:0]    di [MEM_LAT-1];
      logic [XLEN-1:0]    dp [MEM_LAT-1];

      // Valid bits of the read pipeline; reset and redirect kill every stage.
      always_ff @(posedge clk) begin
        if (!rst || redirect_valid)
          dv <= '0;
        else begin
          dv[0] <= issue;
          for (int i = 1; i < MEM_LAT-1; i++)
            dv[i] <= dv[i-1];
        end
      end

      // Word and PC ride along with their valid bit.
      always_ff @(posedge clk) begin
        di[0] <= rd_word;
        dp[0] <= pc;
        for (int i = 1; i < MEM_LAT-1; i++) begin
          di[i] <= di[i-1];
          dp[i] <= dp[i-1];
        end
      end

      // Number of issued reads not yet written into the FIFO.
      always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < MEM_LAT-1; i++)
          inflight = inflight + 3'(dv[i]);
      end

      assign push_valid = dv[MEM_LAT-2];
      assign push_inst  = di[MEM_LAT-2];
      assign push_pc    = dp[MEM_LAT-2];
    end
  endgenerate

  assign push = push_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  // FIFO pointers and occupancy; redirect empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (!rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; only the pointers need clearing.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= push_inst;
      buf_pc[wr_ptr]   <= push_pc;
    end
  end

  // Head outputs are forced to zero while empty so they read 0 out of reset.
  always_comb begin
    inst_valid = (count != '0);
    inst       = inst_valid ? buf_inst[rd_ptr] : '0;
    inst_pc    = inst_valid ? buf_pc[rd_ptr]   : '0;
    fifo_count = count;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: two fetch_queue instances (latency 1 and 3) share one set of
// inputs and are compared every cycle against a queue-based reference model,
// with a few directed scenarios pinned by hand-computed values.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_ready;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;

  logic [1:0]       o_valid;
  logic [1:0][31:0] o_inst;
  logic [1:0][31:0] o_pc;
  logic [1:0][2:0]  o_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .IMEM_WORDS(32), .DEPTH(DEPTH), .MEM_LAT(1)) u0 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .inst_ready(inst_ready),
    .inst_valid(o_valid[0]), .inst(o_inst[0]), .inst_pc(o_pc[0]),
    .fifo_count(o_cnt[0]), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data));

  fetch_queue #(.XLEN(32), .IMEM_WORDS(32), .DEPTH(DEPTH), .MEM_LAT(3)) u1 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .inst_ready(inst_ready),
    .inst_valid(o_valid[1]), .inst(o_inst[1]), .inst_pc(o_pc[1]),
    .fifo_count(o_cnt[1]), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents and in-flight reads as queues, each read
  // tagged with the cycle at whose end it lands in the FIFO.
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
    int          due;
  } item_t;

  item_t       fq [2][$];
  item_t       pq [2][$];
  logic [31:0] mpc [2];
  logic [31:0] mmem [32];
  int          cyc = 0;
  bit          live = 0;

  initial begin
    for (int i = 0; i < 32; i++) mmem[i] = 32'h0;
    mpc[0] = 32'h0;
    mpc[1] = 32'h0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int    lat;
      bit    iss;
      item_t it;
      lat = (k == 0) ? 1 : 3;
      if (!rst) begin
        fq[k].delete();
        pq[k].delete();
        mpc[k] = 32'h0;
      end else if (redirect_valid) begin
        fq[k].delete();
        pq[k].delete();
        mpc[k] = {redirect_target[31:2], 2'b00};
      end else begin
        iss = (fq[k].size() + pq[k].size()) < DEPTH;
        if (fq[k].size() > 0 && inst_ready) void'(fq[k].pop_front());
        if (iss) begin
          it.w   = mmem[mpc[k][6:2]];
          it.pc  = mpc[k];
          it.due = cyc + lat - 1;
          pq[k].push_back(it);
          mpc[k] = mpc[k] + 32'd4;
        end
        while (pq[k].size() > 0 && pq[k][0].due == cyc) begin
          it = pq[k].pop_front();
          fq[k].push_back(it);
        end
      end
    end
    if (rst && prog_we) mmem[prog_addr] = prog_data;
    if (!rst) live = 1;
    cyc++;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d_valid", k), {31'b0, o_valid[k]}, {31'b0, fq[k].size() > 0});
        chk($sformatf("u%0d_count", k), {29'b0, o_cnt[k]}, 32'(fq[k].size()));
        checks++;
        if (o_cnt[k] > DEPTH) begin
          errors++;
          $display("FAIL u%0d_count_bound actual=%0d limit=%0d", k, o_cnt[k], DEPTH);
        end
        if (fq[k].size() > 0) begin
          chk($sformatf("u%0d_inst", k), o_inst[k], fq[k][0].w);
          chk($sformatf("u%0d_pc", k), o_pc[k], fq[k][0].pc);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_valid"}, {31'b0, o_valid[k]}, 32'h0);
      chk({nm, "_inst"}, o_inst[k], 32'h0);
      chk({nm, "_pc"}, o_pc[k], 32'h0);
      chk({nm, "_count"}, {29'b0, o_cnt[k]}, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    inst_ready = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    step(); step();
    chk_zero("reset");

    // Load imem[i] = 0x100+i while fetch free-runs.
    rst = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = 32'h100 + i;
      step();
    end
    prog_we = 1'b0;

    // Release from reset with decode always ready.
    rst = 1'b0; step();
    rst = 1'b1; inst_ready = 1'b1;
    step();
    chk("rel_u0_valid_c1", {31'b0, o_valid[0]}, 32'h1);
    chk("rel_u0_inst_c1", o_inst[0], 32'h100);
    chk("rel_u0_pc_c1", o_pc[0], 32'h0);
    chk("rel_u1_valid_c1", {31'b0, o_valid[1]}, 32'h0);
    step();
    chk("rel_u0_inst_c2", o_inst[0], 32'h101);
    chk("rel_u0_pc_c2", o_pc[0], 32'h4);
    chk("rel_u1_valid_c2", {31'b0, o_valid[1]}, 32'h0);
    step();
    chk("rel_u1_valid_c3", {31'b0, o_valid[1]}, 32'h1);
    chk("rel_u1_pc_c3", o_pc[1], 32'h0);
    chk("rel_u0_pc_c3", o_pc[0], 32'h8);

    // Back-pressure: queue fills to DEPTH and the head holds.
    rst = 1'b0; step();
    rst = 1'b1; inst_ready = 1'b0;
    repeat (10) step();
    chk("bp_u0_count", {29'b0, o_cnt[0]}, 32'd4);
    chk("bp_u1_count", {29'b0, o_cnt[1]}, 32'd4);
    chk("bp_u0_inst", o_inst[0], 32'h100);
    chk("bp_u0_pc", o_pc[0], 32'h0);
    inst_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("bp_u0_flow_pc", o_pc[0], 32'(4 * j));
      chk("bp_u0_flow_inst", o_inst[0], 32'h100 + j);
    end

    // Redirect to an unaligned target with entries queued.
    inst_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_target = 32'h1E;
    step();
    redirect_valid = 1'b0;
    chk("rd_u0_count", {29'b0, o_cnt[0]}, 32'h0);
    chk("rd_u1_count", {29'b0, o_cnt[1]}, 32'h0);
    step();
    chk("rd_u0_pc", o_pc[0], 32'h1C);
    chk("rd_u0_inst", o_inst[0], 32'h107);
    chk("rd_u1_valid_c2", {31'b0, o_valid[1]}, 32'h0);
    step();
    chk("rd_u1_valid_c3", {31'b0, o_valid[1]}, 32'h0);
    step();
    chk("rd_u1_valid_c4", {31'b0, o_valid[1]}, 32'h1);
    chk("rd_u1_pc", o_pc[1], 32'h1C);

    // Imem index wraps past the last word.
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h7C;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_u0_pc0", o_pc[0], 32'h7C);
    chk("wrap_u0_inst0", o_inst[0], 32'h11F);
    step();
    chk("wrap_u0_pc1", o_pc[0], 32'h80);
    chk("wrap_u0_inst1", o_inst[0], 32'h100);
    step();
    chk("wrap_u1_pc0", o_pc[1], 32'h7C);
    step();
    chk("wrap_u1_pc1", o_pc[1], 32'h80);
    chk("wrap_u1_inst1", o_inst[1], 32'h100);

    // Write imem[2] in the cycle that PC 8 issues.
    redirect_valid = 1'b1; redirect_target = 32'h8;
    step();
    redirect_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 32'hDEAD;
    step();
    prog_we = 1'b0;
    chk("prog_old_u0_pc", o_pc[0], 32'h8);
    chk("prog_old_u0_inst", o_inst[0], 32'h102);
    step(); step();
    chk("prog_old_u1_inst", o_inst[1], 32'h102);
    redirect_valid = 1'b1; redirect_target = 32'h8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("prog_new_u0_inst", o_inst[0], 32'hDEAD);
    step(); step();
    chk("prog_new_u1_inst", o_inst[1], 32'hDEAD);

    // One-cycle reset mid-stream with entries queued.
    inst_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_zero("midrst");
    rst = 1'b1; inst_ready = 1'b1;
    step();
    chk("midrst_u0_pc", o_pc[0], 32'h0);
    chk("midrst_u0_inst", o_inst[0], 32'h100);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      inst_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
      prog_we         = ($urandom_range(0, 7) == 0);
      prog_addr       = 5'($urandom_range(0, 31));
      prog_data       = $urandom;
      rst             = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1; redirect_valid = 1'b0; prog_we = 1'b0; inst_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
